// File: rtl/fft_pkg.sv
// Shared FFT definitions: sample width, transform size, complex sample type
// and the SDF butterfly stage state encoding.
package fft_pkg;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned FFT_N  = 32;

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BFLY  = 2'd2,
    DRAIN = 2'd3
  } bf_state_e;

endpackage

// File: rtl/sdf_bf_stage_if.sv
// Bundle of all data/qualifier signals of one SDF butterfly stage.
//   in_valid, in_r, in_i      : upstream sample into the stage
//   sr_out_r, sr_out_i        : head of the external DELAY-deep delay line
//   sr_in_r, sr_in_i          : tail feed from the stage into the delay line
//   out_valid, out_r, out_i   : registered butterfly result
//   out_k                     : index of the result within its frame
//   err                       : one-cycle pulse on a mid-frame gap
// Modports: master = surrounding system (source, delay line, sink),
//           slave  = the butterfly stage.
interface sdf_bf_stage_if
  import fft_pkg::*;
#(
  parameter int unsigned DELAY = 16
) ();

  localparam int unsigned K_W = $clog2(2 * DELAY) + 1;

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_r;
  logic signed [DATA_W-1:0] in_i;
  logic signed [DATA_W-1:0] sr_out_r;
  logic signed [DATA_W-1:0] sr_out_i;
  logic signed [DATA_W-1:0] sr_in_r;
  logic signed [DATA_W-1:0] sr_in_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_r;
  logic signed [DATA_W-1:0] out_i;
  logic [K_W-1:0]           out_k;
  logic                     err;

  modport master (
    output in_valid, in_r, in_i, sr_out_r, sr_out_i,
    input  sr_in_r, sr_in_i, out_valid, out_r, out_i, out_k, err
  );

  modport slave (
    input  in_valid, in_r, in_i, sr_out_r, sr_out_i,
    output sr_in_r, sr_in_i, out_valid, out_r, out_i, out_k, err
  );

endinterface

// File: rtl/sdf_bf_addsub.sv
// Combinational complex add/subtract for the SDF butterfly.
//   a    : delay-line head sample
//   b    : incoming sample
//   sum  : a + b, narrowed to DATA_W bits
//   diff : a - b, narrowed to DATA_W bits
// Build option: SDF_BF_SAT_EN defined -> saturate on overflow;
//               undefined             -> wrap (keep the low DATA_W bits).
module sdf_bf_addsub
  import fft_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t sum,
  output cplx_t diff
);

  localparam int unsigned EXT_W = DATA_W + 1;

  function automatic logic signed [DATA_W-1:0] narrow(input logic [EXT_W-1:0] x);
`ifdef SDF_BF_SAT_EN
    // Top two bits differ only when the result left the DATA_W range.
    if (x[EXT_W-1] != x[EXT_W-2]) begin
      narrow = x[EXT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      narrow = x[DATA_W-1:0];
    end
`else
    narrow = x[DATA_W-1:0];
`endif
  endfunction

  logic [EXT_W-1:0] sum_r, sum_i, diff_r, diff_i;

  always_comb begin
    sum_r  = {a.r[DATA_W-1], a.r} + {b.r[DATA_W-1], b.r};
    sum_i  = {a.i[DATA_W-1], a.i} + {b.i[DATA_W-1], b.i};
    diff_r = {a.r[DATA_W-1], a.r} - {b.r[DATA_W-1], b.r};
    diff_i = {a.i[DATA_W-1], a.i} - {b.i[DATA_W-1], b.i};
    sum    = '{r: narrow(sum_r), i: narrow(sum_i)};
    diff   = '{r: narrow(diff_r), i: narrow(diff_i)};
  end

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with an external delay line.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : sdf_bf_stage_if slave (sample in, delay-line feed/head, result out, err)
// A frame is 2*DELAY contiguous samples. The first half is parked in the delay
// line; the second half is combined with it: sums go out immediately, differences
// go back into the delay line and are emitted during the next frame's first half
// (or during DRAIN when no frame follows).
// Build option: SDF_BF_SAT_EN (see sdf_bf_addsub) selects saturating arithmetic.
module sdf_bf_stage
  import fft_pkg::*;
#(
  parameter int unsigned DELAY = 16
) (
  input logic           clk,
  input logic           rst,
  sdf_bf_stage_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(2 * DELAY);
  localparam int unsigned K_W   = CNT_W + 1;

  bf_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  cplx_t            out_q, out_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             ov_q, ov_d;
  logic             err_q, err_d;

  cplx_t in_c, sro_c, sum_c, diff_c, sri_c;
  logic  do_fill, do_bfly, do_drain, do_err;
  logic  at_half, at_last;

  assign in_c    = '{r: bus.in_r, i: bus.in_i};
  assign sro_c   = '{r: bus.sr_out_r, i: bus.sr_out_i};
  assign at_half = (cnt_q == CNT_W'(DELAY - 1));
  assign at_last = (cnt_q == CNT_W'(2 * DELAY - 1));

  sdf_bf_addsub u_addsub (
    .a    (sro_c),
    .b    (in_c),
    .sum  (sum_c),
    .diff (diff_c)
  );

  // Action decode. FILL with cnt=0 is only reached right after a frame end, so a
  // missing sample there is a frame boundary (start draining), not an error.
  always_comb begin
    do_fill  = 1'b0;
    do_bfly  = 1'b0;
    do_drain = 1'b0;
    do_err   = 1'b0;
    unique case (state_q)
      IDLE: do_fill = bus.in_valid;
      FILL: begin
        if (bus.in_valid)        do_fill  = 1'b1;
        else if (cnt_q == '0)    do_drain = 1'b1;
        else                     do_err   = 1'b1;
      end
      BFLY: begin
        if (bus.in_valid) do_bfly = 1'b1;
        else              do_err  = 1'b1;
      end
      DRAIN: do_drain = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    out_d   = out_q;
    k_d     = k_q;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    sri_c   = '0;

    if (do_fill) begin
      // Park the sample; the head of the line holds a previous-frame difference.
      sri_c   = in_c;
      out_d   = sro_c;
      ov_d    = pend_q;
      k_d     = K_W'(cnt_q) + K_W'(DELAY);
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = at_half ? BFLY : FILL;
    end

    if (do_bfly) begin
      sri_c   = diff_c;
      out_d   = sum_c;
      ov_d    = 1'b1;
      k_d     = K_W'(cnt_q) - K_W'(DELAY);
      pend_d  = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = at_last ? FILL : BFLY;
    end

    if (do_drain) begin
      out_d = sro_c;
      ov_d  = 1'b1;
      k_d   = K_W'(cnt_q) + K_W'(DELAY);
      if (at_half) begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else begin
        state_d = DRAIN;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end

    if (do_err) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end

    // Keep the delay line fed with zeros while held in reset.
    if (!rst) sri_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      out_q   <= '0;
      k_q     <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      k_q     <= k_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign bus.sr_in_r   = sri_c.r;
  assign bus.sr_in_i   = sri_c.i;
  assign bus.out_valid = ov_q;
  assign bus.out_r     = out_q.r;
  assign bus.out_i     = out_q.i;
  assign bus.out_k     = k_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage: a DELAY=2 instance for frame/drain/error/reset
// cases and a DELAY=16 instance for a full ramp. Delay lines are modelled here.
module tb_sdf_bf_stage;
  import fft_pkg::*;

  logic clk;
  logic rst;

  sdf_bf_stage_if #(.DELAY(2))  a_if ();
  sdf_bf_stage_if #(.DELAY(16)) b_if ();

  sdf_bf_stage #(.DELAY(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  sdf_bf_stage #(.DELAY(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // External delay lines, shifting every clock.
  logic [DATA_W-1:0] dla_r [2]  = '{default: '0};
  logic [DATA_W-1:0] dla_i [2]  = '{default: '0};
  logic [DATA_W-1:0] dlb_r [16] = '{default: '0};
  logic [DATA_W-1:0] dlb_i [16] = '{default: '0};

  always @(posedge clk) begin
    dla_r[0] <= a_if.sr_in_r;
    dla_i[0] <= a_if.sr_in_i;
    for (int n = 1; n < 2; n++) begin
      dla_r[n] <= dla_r[n-1];
      dla_i[n] <= dla_i[n-1];
    end
    dlb_r[0] <= b_if.sr_in_r;
    dlb_i[0] <= b_if.sr_in_i;
    for (int m = 1; m < 16; m++) begin
      dlb_r[m] <= dlb_r[m-1];
      dlb_i[m] <= dlb_i[m-1];
    end
  end

  assign a_if.sr_out_r = dla_r[1];
  assign a_if.sr_out_i = dla_i[1];
  assign b_if.sr_out_r = dlb_r[15];
  assign b_if.sr_out_i = dlb_i[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_run  = 0;
  int    n_fail = 0;
  string grp    = "init";

`ifdef SDF_BF_SAT_EN
  localparam int SAT_SUM = 262143;
`else
  localparam int SAT_SUM = -262144;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d expected %0d", grp, tag, got, exp);
    end
  endtask

  // Drive one cycle on DUT A, then check the registered result of that cycle.
  task automatic step_a(input bit v, input int x, input bit ev, input int er, input int ek,
                        input bit eerr);
    a_if.in_valid = v;
    a_if.in_r     = DATA_W'(x);
    a_if.in_i     = '0;
    @(posedge clk);
    #1;
    chk("valid", int'(a_if.out_valid), int'(ev));
    chk("err", int'(a_if.err), int'(eerr));
    if (ev) begin
      chk("out_r", int'(a_if.out_r), er);
      chk("out_i", int'(a_if.out_i), 0);
      chk("out_k", int'(a_if.out_k), ek);
    end
  endtask

  task automatic step_b(input bit v, input int x, input bit ev, input int er, input int ek);
    b_if.in_valid = v;
    b_if.in_r     = DATA_W'(x);
    b_if.in_i     = '0;
    @(posedge clk);
    #1;
    chk("b_valid", int'(b_if.out_valid), int'(ev));
    if (ev) begin
      chk("b_out_r", int'(b_if.out_r), er);
      chk("b_out_k", int'(b_if.out_k), ek);
    end
  endtask

  // Frame 1,2,3,4 followed by idle: 4,6 then drained -2,-2.
  task automatic frame_1234_a();
    step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 2, 0, 0, 0, 0);
    step_a(1, 3, 1, 4, 0, 0);
    step_a(1, 4, 1, 6, 1, 0);
    step_a(0, 0, 1, -2, 2, 0);
    step_a(0, 0, 1, -2, 3, 0);
    step_a(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_r     = DATA_W'(5);
    a_if.in_i     = '0;
    b_if.in_valid = 1'b0;
    b_if.in_r     = '0;
    b_if.in_i     = '0;
    #2 rst = 1'b0;
    #1;
    grp = "reset";
    chk("valid", int'(a_if.out_valid), 0);
    chk("out_r", int'(a_if.out_r), 0);
    chk("out_k", int'(a_if.out_k), 0);
    chk("err", int'(a_if.err), 0);
    chk("sr_in_r", int'(a_if.sr_in_r), 0);
    chk("b_valid", int'(b_if.out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    grp = "single";
    a_if.in_valid = 1'b1;
    a_if.in_r     = DATA_W'(1);
    #1 chk("sr_in_fill", int'(a_if.sr_in_r), 1);
    step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 2, 0, 0, 0, 0);
    a_if.in_r = DATA_W'(3);
    #1 chk("sr_in_bfly", int'(a_if.sr_in_r), -2);
    step_a(1, 3, 1, 4, 0, 0);
    step_a(1, 4, 1, 6, 1, 0);
    step_a(0, 0, 1, -2, 2, 0);
    #1 chk("sr_in_drain", int'(a_if.sr_in_r), 0);
    step_a(0, 0, 1, -2, 3, 0);
    step_a(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);

    grp = "b2b";
    step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 2, 0, 0, 0, 0);
    step_a(1, 3, 1, 4, 0, 0);
    step_a(1, 4, 1, 6, 1, 0);
    step_a(1, 5, 1, -2, 2, 0);
    step_a(1, 6, 1, -2, 3, 0);
    step_a(1, 7, 1, 12, 0, 0);
    step_a(1, 8, 1, 14, 1, 0);
    step_a(0, 0, 1, -2, 2, 0);
    step_a(0, 0, 1, -2, 3, 0);
    step_a(0, 0, 0, 0, 0, 0);

    grp = "ovf";
    step_a(1, 262143, 0, 0, 0, 0);
    step_a(1, 0, 0, 0, 0, 0);
    step_a(1, 1, 1, SAT_SUM, 0, 0);
    step_a(1, 0, 1, 0, 1, 0);
    step_a(0, 0, 1, 262142, 2, 0);
    step_a(0, 0, 1, 0, 3, 0);
    step_a(0, 0, 0, 0, 0, 0);

    grp = "gap";
    step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 2, 0, 0, 0, 0);
    step_a(1, 3, 1, 4, 0, 0);
    step_a(0, 0, 0, 0, 0, 1);
    step_a(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);
    grp = "gap_next";
    frame_1234_a();

    grp = "rst_drain";
    step_a(1, 1, 0, 0, 0, 0);
    step_a(1, 2, 0, 0, 0, 0);
    step_a(1, 3, 1, 4, 0, 0);
    step_a(1, 4, 1, 6, 1, 0);
    step_a(0, 0, 1, -2, 2, 0);
    #2 rst = 1'b0;
    #1;
    chk("valid", int'(a_if.out_valid), 0);
    chk("out_r", int'(a_if.out_r), 0);
    chk("out_k", int'(a_if.out_k), 0);
    chk("err", int'(a_if.err), 0);
    chk("sr_in_r", int'(a_if.sr_in_r), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step_a(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0, 0);
    grp = "rst_next";
    frame_1234_a();

    grp = "ramp16";
    for (int i = 0; i < 32; i++) begin
      step_b(1, i, (i >= 16), 16 + 2 * (i - 16), i - 16);
    end
    for (int j = 0; j < 16; j++) begin
      step_b(0, 0, 1, -16, 16 + j);
    end
    step_b(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
